// File: rtl/uart8_tx_fifo_if.sv
// Host/transmitter-facing signal bundle for uart8_tx_fifo.
// The slave modport is the FIFO itself. The master modport is whatever sits around it:
// host push logic on one side and the UART transmitter's busy flag on the other.
interface uart8_tx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          sent;
  logic          timeout;

  modport master (
    output wr_en, wr_data, tx_busy,
    input  full, empty, count, overflow, tx_start, tx_data, sent, timeout
  );

  modport slave (
    input  wr_en, wr_data, tx_busy,
    output full, empty, count, overflow, tx_start, tx_data, sent, timeout
  );
endinterface

// File: rtl/uart8_tx_fifo.sv
// Byte FIFO plus launch sequencer feeding an 8-bit UART transmitter.
// Each byte is popped into a holding register. That register stays frozen until the
// transmitter reports the frame done, or until a launch is abandoned on timeout.
module uart8_tx_fifo #(
  parameter int DEPTH          = 16,
  parameter int LAUNCH_TIMEOUT = 1048576
) (
  input  logic             clk,
  input  logic             rst_n,
  uart8_tx_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(LAUNCH_TIMEOUT);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(LAUNCH_TIMEOUT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, overflow_q;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, sent_q, sent_d, timeout_q, timeout_d;
  logic          push, pop;

  // A full FIFO rejects the push even when a pop happens on the same edge.
  assign push = bus.wr_en && !full_q;

  // Occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage write port.
  // NOTE: the array carries no reset; its contents are don't-care until written, and a reset
  // would turn the array into plain flops with a reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.wr_data;
  end

  // Pointers, occupancy flags and the overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      full_q     <= (count_d == COUNT_FULL);
      empty_q    <= (count_d == '0);
      overflow_q <= bus.wr_en && full_q;
    end
  end

  // Sequencer next-state: pop into the holding register, wait for busy, then wait for the frame to end.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    sent_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop       = 1'b1;
          tx_data_d = mem[rd_ptr_q];
          timer_d   = '0;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        if (bus.tx_busy) begin
          state_d = BUSY;
        end else if (timer_q == TIMER_MAX) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      BUSY: begin
        if (!bus.tx_busy) begin
          sent_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers; tx_start is registered from the next state so it leaves a flop directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      sent_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= (state_d == LAUNCH);
      sent_q     <= sent_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.sent     = sent_q;
  assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_uart8_tx_fifo.sv
// Directed bench for uart8_tx_fifo.
// Stimulus queues each expected launch as it pushes a byte. A transmitter model pops the
// queue on every launch it sees and checks the byte and the start/busy/sent handshake.
module tb_uart8_tx_fifo;
  localparam int DEPTH = 16;
  localparam int LT    = 8;
  localparam int BUSY_DELAY = 3;

  typedef struct packed {
    logic [7:0] data;
    logic       to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  uart8_tx_fifo_if #(.DEPTH(DEPTH)) bus();

  uart8_tx_fifo #(.DEPTH(DEPTH), .LAUNCH_TIMEOUT(LT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   frames_done = 0;
  int   timeouts_done = 0;
  int   frame_len = 100;
  bit   model_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one push for one cycle. Queue the byte if the FIFO is expected to accept it.
  task automatic push_byte(input logic [7:0] d, input bit accept, input bit to);
    exp_t e;
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    if (accept) begin
      e.data = d;
      e.to   = to;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frames_done", 32'(frames_done), 32'(target));
  endtask

  // Transmitter model and scoreboard monitor.
  initial begin : xmit_model
    exp_t       e;
    logic [7:0] held;
    int         n, guard;
    bit         stable, sent_early;
    forever begin
      @(negedge clk);
      if (model_en && rst_n && bus.tx_start) begin
        if (exp_q.size() == 0) begin
          check("unexpected_launch", 32'(bus.tx_data), 32'hFFFF_FFFF);
          wait (!bus.tx_start);
        end else begin
          e    = exp_q.pop_front();
          held = bus.tx_data;
          check("launch_data", 32'(bus.tx_data), 32'(e.data));
          if (e.to) begin
            n = 1; guard = 0; sent_early = 1'b0;
            do begin
              @(negedge clk);
              if (bus.tx_start) n++;
              if (bus.sent) sent_early = 1'b1;
              guard++;
            end while (bus.tx_start && guard < 64);
            check("timeout_start_cycles", 32'(n), 32'(LT));
            check("timeout_pulse", 32'(bus.timeout), 32'd1);
            check("timeout_no_sent", 32'(sent_early), 32'd0);
            timeouts_done++;
          end else begin
            repeat (BUSY_DELAY) @(negedge clk);
            check("start_held", 32'(bus.tx_start), 32'd1);
            bus.tx_busy = 1'b1;
            @(negedge clk);
            check("start_drop", 32'(bus.tx_start), 32'd0);
            stable = 1'b1; sent_early = 1'b0;
            repeat (frame_len - 1) begin
              @(negedge clk);
              if (bus.tx_data !== held) stable = 1'b0;
              if (bus.sent) sent_early = 1'b1;
            end
            check("data_stable", 32'(stable), 32'd1);
            check("no_early_sent", 32'(sent_early), 32'd0);
            bus.tx_busy = 1'b0;
            @(negedge clk);
            check("sent_pulse", 32'(bus.sent), 32'd1);
            frames_done++;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int  n;
    bit  seen;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.tx_busy = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_empty",    32'(bus.empty),    32'd1);
    check("rst_full",     32'(bus.full),     32'd0);
    check("rst_count",    32'(bus.count),    32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data",  32'(bus.tx_data),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte with a long frame.
    frame_len = 100;
    push_byte(8'hA5, 1'b1, 1'b0);
    check("push_empty", 32'(bus.empty),    32'd0);
    check("push_count", 32'(bus.count),    32'd1);
    check("push_start", 32'(bus.tx_start), 32'd0);
    @(negedge clk);
    check("launch_latency", 32'(bus.tx_start), 32'd1);
    check("launch_byte",    32'(bus.tx_data),  32'hA5);
    check("pop_count",      32'(bus.count),    32'd0);
    wait_frames(1, 300);
    check("single_empty", 32'(bus.empty), 32'd1);
    @(negedge clk);
    check("sent_one_cycle", 32'(bus.sent), 32'd0);

    // Burst: 17 accepted bytes (one popped early), then an 18th that overflows.
    frame_len = 30;
    for (int i = 1; i <= 18; i++) begin
      push_byte(8'(i), i <= 17, 1'b0);
      if (i == 17) begin
        check("burst_full",  32'(bus.full),  32'd1);
        check("burst_count", 32'(bus.count), 32'd16);
      end
    end
    check("burst_overflow", 32'(bus.overflow), 32'd1);
    @(negedge clk);
    check("overflow_one_cycle", 32'(bus.overflow), 32'd0);

    // Push while full on the very edge that pops.
    n = 0;
    while (!bus.sent && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("first_burst_sent", 32'(bus.sent), 32'd1);
    push_byte(8'h99, 1'b0, 1'b0);
    check("full_pop_overflow", 32'(bus.overflow), 32'd1);
    check("full_pop_count",    32'(bus.count),    32'(DEPTH - 1));
    check("full_pop_full",     32'(bus.full),     32'd0);
    wait_frames(18, 17 * 50);

    // Pointer wrap: four batches of ten, each drained before the next.
    frame_len = 5;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) push_byte(8'((b * 10 + i) * 37 + 3), 1'b1, 1'b0);
      wait_frames(18 + (b + 1) * 10, 10 * 20);
    end
    check("wrap_empty", 32'(bus.empty), 32'd1);

    // Launch timeout: the transmitter never answers.
    push_byte(8'h3C, 1'b1, 1'b1);
    n = 0;
    while (timeouts_done < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeouts_done", 32'(timeouts_done), 32'd1);
    check("timeout_frames", 32'(frames_done), 32'd58);
    @(negedge clk);
    check("timeout_one_cycle", 32'(bus.timeout), 32'd0);
    check("timeout_empty",     32'(bus.empty),   32'd1);

    // Reset in BUSY with three bytes still queued.
    model_en = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'hB1 + 8'(i), 1'b0, 1'b0);
    n = 0;
    while (!bus.tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("manual_launch", 32'(bus.tx_data), 32'hB1);
    bus.tx_busy = 1'b1;
    @(negedge clk);
    check("manual_busy_start", 32'(bus.tx_start), 32'd0);
    check("manual_busy_count", 32'(bus.count),    32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_tx_start", 32'(bus.tx_start), 32'd0);
    check("async_tx_data",  32'(bus.tx_data),  32'd0);
    check("async_count",    32'(bus.count),    32'd0);
    check("async_empty",    32'(bus.empty),    32'd1);
    check("async_full",     32'(bus.full),     32'd0);
    check("async_pulses",   32'({bus.sent, bus.timeout, bus.overflow}), 32'd0);
    bus.tx_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.tx_start || bus.sent) seen = 1'b1;
    end
    check("post_reset_quiet", 32'(seen), 32'd0);
    model_en = 1'b1;
    push_byte(8'h77, 1'b1, 1'b0);
    wait_frames(59, 100);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
